w32_op_server: RTL and testbench

- Request/response execution server for 32-bit word operations (add, sub, and, xor, not, rotate/shift right).
- Sits between a sequencing FSM (e.g. a hash-round controller) and the W32 arithmetic, as the responder end of a valid/ready op-request interface.
- Two-stage registered pipeline with full backpressure; one result per cycle sustained, in order, tag passed through.

---
 rtl/w32_op_server.sv | 129 ++++++++++++
 tb/tb_w32_op_server.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/w32_op_server.sv
// Two-stage valid/ready execution server for 32-bit word ops.
// S1 holds the accepted request, S2 holds the registered result that drives rsp_*.
module w32_op_server #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_NOT  = 3'd4,
    OP_ROTR = 3'd5,
    OP_SHR  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  logic             s1Valid_q;
  op_e              s1Op_q;
  logic [31:0]      s1A_q;
  logic [31:0]      s1B_q;
  logic [TAG_W-1:0] s1Tag_q;

  logic             s2Valid_q;
  logic [31:0]      s2Data_q;
  logic             s2Carry_q;
  logic             s2Err_q;
  logic [TAG_W-1:0] s2Tag_q;

  logic [31:0]      resData_d;
  logic             resCarry_d;
  logic             resErr_d;
  logic [32:0]      sumWide;
  logic [4:0]       shamt;
  logic             s2Free;
  logic             s1Advance;
  logic             reqFire;

  assign s2Free    = !s2Valid_q || rsp_ready;
  assign s1Advance = s1Valid_q && s2Free;
  assign req_ready = !s1Valid_q || s2Free;
  assign reqFire   = req_valid && req_ready;

  assign sumWide = {1'b0, s1A_q} + {1'b0, s1B_q};
  assign shamt   = s1B_q[4:0];

  // A left shift by 32 yields zero, so n=0 rotation falls out as a unchanged.
  always_comb begin
    resData_d  = '0;
    resCarry_d = 1'b0;
    resErr_d   = 1'b0;
    case (s1Op_q)
      OP_ADD: begin
        resData_d  = sumWide[31:0];
        resCarry_d = sumWide[32];
      end
      OP_SUB: begin
        resData_d  = s1A_q - s1B_q;
        resCarry_d = (s1A_q < s1B_q);
      end
      OP_AND:  resData_d = s1A_q & s1B_q;
      OP_XOR:  resData_d = s1A_q ^ s1B_q;
      OP_NOT:  resData_d = ~s1A_q;
      OP_ROTR: resData_d = (s1A_q >> shamt) | (s1A_q << (6'd32 - {1'b0, shamt}));
      OP_SHR:  resData_d = s1A_q >> shamt;
      OP_RSV:  resErr_d  = 1'b1;
      default: resErr_d  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= OP_ADD;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Tag_q   <= '0;
    end else begin
      if (req_ready) s1Valid_q <= req_valid;
      if (reqFire) begin
        s1Op_q  <= op_e'(req_op);
        s1A_q   <= req_a;
        s1B_q   <= req_b;
        s1Tag_q <= req_tag;
      end
    end
  end

  // Only the valid bit clears on drain; data/tag may hold stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Carry_q <= 1'b0;
      s2Err_q   <= 1'b0;
      s2Tag_q   <= '0;
    end else begin
      if (s2Free) s2Valid_q <= s1Valid_q;
      if (s1Advance) begin
        s2Data_q  <= resData_d;
        s2Carry_q <= resCarry_d;
        s2Err_q   <= resErr_d;
        s2Tag_q   <= s1Tag_q;
      end
    end
  end

  assign rsp_valid = s2Valid_q;
  assign rsp_data  = s2Data_q;
  assign rsp_carry = s2Carry_q;
  assign rsp_err   = s2Err_q;
  assign rsp_tag   = s2Tag_q;

endmodule

// File: tb/tb_w32_op_server.sv
// Directed bench for w32_op_server: hand-computed vectors, an in-order
// expected-response queue, stall/latency/reset checks.
module tb_w32_op_server;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_err;
  logic [3:0]  rsp_tag;

  int   totalChecks = 0;
  int   badChecks = 0;
  int   respCount = 0;
  int   countMark;
  rsp_t expQ[$];

  w32_op_server #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveReq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] expData,
                          input logic expCarry, input logic expErr);
    rsp_t e;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    e.data = expData; e.carry = expCarry; e.err = expErr; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic waitAccept();
    logic accepted;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = req_ready;
      tick();
    end
    if (!accepted) checkOutput("accept_timeout", {63'b0, accepted}, 64'd1);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] tag, input logic [31:0] expData,
                               input logic expCarry, input logic expErr);
    driveReq(op, a, b, tag, expData, expCarry, expErr);
    waitAccept();
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && expQ.size() != 0; i++) tick();
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  // Response monitor: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_rsp", {63'b0, rsp_valid}, 64'd0);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_data", {32'b0, rsp_data}, {32'b0, e.data});
        checkOutput("rsp_carry", {63'b0, rsp_carry}, {63'b0, e.carry});
        checkOutput("rsp_err", {63'b0, rsp_err}, {63'b0, e.err});
        checkOutput("rsp_tag", {60'b0, rsp_tag}, {60'b0, e.tag});
        respCount++;
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b1;
    #3;
    checkOutput("reset_valid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("reset_data", {32'b0, rsp_data}, 64'd0);
    checkOutput("reset_carry", {63'b0, rsp_carry}, 64'd0);
    checkOutput("reset_err", {63'b0, rsp_err}, 64'd0);
    checkOutput("reset_tag", {60'b0, rsp_tag}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {63'b0, req_ready}, 64'd1);
    tick();

    // Single ADD with carry-out and latency check
    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'h0000_0000, 1'b1, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_not_yet", {63'b0, rsp_valid}, 64'd0);
    @(negedge clk);
    checkOutput("latency_valid", {63'b0, rsp_valid}, 64'd1);
    tick();
    waitDrain();

    // Back-to-back op sweep: one response per cycle
    countMark = respCount;
    applyStimulus(3'd1, 32'h1234_5678, 32'h0000_000F, 4'd1, 32'h1234_5669, 1'b0, 1'b0);
    applyStimulus(3'd2, 32'h1234_5678, 32'h0000_000F, 4'd2, 32'h0000_0008, 1'b0, 1'b0);
    applyStimulus(3'd3, 32'h1234_5678, 32'h0000_000F, 4'd3, 32'h1234_5677, 1'b0, 1'b0);
    applyStimulus(3'd4, 32'h1234_5678, 32'h0000_000F, 4'd4, 32'hEDCB_A987, 1'b0, 1'b0);
    applyStimulus(3'd5, 32'h1234_5678, 32'h0000_000F, 4'd5, 32'hACF0_2468, 1'b0, 1'b0);
    applyStimulus(3'd6, 32'h1234_5678, 32'h0000_000F, 4'd6, 32'h0000_2468, 1'b0, 1'b0);
    req_valid = 1'b0;
    checkOutput("sweep_rate", 64'(respCount - countMark), 64'd4);
    waitDrain();

    // Boundaries: borrow, rotate by 32 (n=0), shift by 31, add without carry
    applyStimulus(3'd1, 32'h0000_0000, 32'h0000_0001, 4'd9, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus(3'd5, 32'hDEAD_BEEF, 32'h0000_0020, 4'd10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(3'd6, 32'h8000_0000, 32'h0000_001F, 4'd11, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(3'd0, 32'h0000_0005, 32'h0000_0007, 4'd12, 32'h0000_000C, 1'b0, 1'b0);
    req_valid = 1'b0;
    waitDrain();

    // Backpressure: two accepted, third stalls, outputs hold
    countMark = respCount;
    rsp_ready = 1'b0;
    applyStimulus(3'd0, 32'h0000_0001, 32'h0000_0002, 4'd1, 32'h0000_0003, 1'b0, 1'b0);
    applyStimulus(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2, 32'h0FF0_0FF0, 1'b0, 1'b0);
    driveReq(3'd2, 32'hFFFF_0000, 32'h1234_5678, 4'd3, 32'h1234_0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_ready", {63'b0, req_ready}, 64'd0);
      checkOutput("stall_valid", {63'b0, rsp_valid}, 64'd1);
      checkOutput("stall_data", {32'b0, rsp_data}, 64'h3);
      checkOutput("stall_tag", {60'b0, rsp_tag}, 64'd1);
    end
    tick();
    rsp_ready = 1'b1;
    waitAccept();
    req_valid = 1'b0;
    waitDrain();
    checkOutput("stall_drain_count", 64'(respCount - countMark), 64'd3);

    // Reserved opcode between two ADDs
    applyStimulus(3'd0, 32'h0000_0010, 32'h0000_0001, 4'd4, 32'h0000_0011, 1'b0, 1'b0);
    applyStimulus(3'd7, 32'hAAAA_AAAA, 32'h5555_5555, 4'd5, 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus(3'd0, 32'h8000_0000, 32'h8000_0000, 4'd6, 32'h0000_0000, 1'b1, 1'b0);
    req_valid = 1'b0;
    waitDrain();

    // Async reset with two requests in flight
    rsp_ready = 1'b0;
    applyStimulus(3'd0, 32'h0000_0010, 32'h0000_0020, 4'd7, 32'h0000_0030, 1'b0, 1'b0);
    applyStimulus(3'd1, 32'h0000_0050, 32'h0000_0020, 4'd8, 32'h0000_0030, 1'b0, 1'b0);
    req_valid = 1'b0;
    checkOutput("pre_reset_valid", {63'b0, rsp_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("async_rst_data", {32'b0, rsp_data}, 64'd0);
    checkOutput("async_rst_tag", {60'b0, rsp_tag}, 64'd0);
    expQ.delete();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst2", {63'b0, req_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_stale_rsp", {63'b0, rsp_valid}, 64'd0);
    end

    checkOutput("resp_total", 64'(respCount), 64'd17);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
